// File: rtl/pipe_ctrl_pkg.sv
// Shared types, default sizes and the vector-address helper for the interrupt/pipeline controller.
package pipe_ctrl_pkg;

    localparam int             PC_W_DEF      = 10;
    localparam int             DEPTH_DEF     = 3;
    localparam int             NUM_IRQ_DEF   = 4;
    localparam logic [9:0]     VEC_BASE_DEF  = 10'h300;
    localparam int             VEC_SHIFT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT,
        ST_SERVICE,
        ST_RETURN
    } state_e;

    // Caller truncates the result to its PC width, giving wrap-around.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] idx,
                                             input int          shift);
        return base + (idx << shift);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder with a valid flag.
module irq_prio_enc
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    localparam int IDX_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scanning downward lets the lowest set index overwrite higher ones.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pipe_int_ctrl.sv
// Interrupt arbitration and pipeline drain/redirect controller with EPC save/restore.
// Define INT_NESTING_EN to allow lower-index requests to pre-empt a running handler (2-deep EPC stack).
module pipe_int_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              DEPTH     = DEPTH_DEF,
    parameter int              NUM_IRQ   = NUM_IRQ_DEF,
    parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(VEC_BASE_DEF),
    parameter int              VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic               branch_pending,
    input  logic               eret,
    output logic               stall_fetch,
    output logic [DEPTH-1:0]   flush,
    output logic               pc_redirect_valid,
    output logic [PC_W-1:0]    pc_redirect,
    output logic [PC_W-1:0]    epc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               int_active,
    output logic               available_for_int
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PC_W-1:0]      epc_q, epc_d;
    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_IRQ-1:0]   req_masked;
    logic                 nest_d;

    logic                 stall_q, redir_valid_q, active_q, avail_q;
    logic [DEPTH-1:0]     flush_q, flush_d;
    logic [PC_W-1:0]      redir_pc_q, redir_pc_d;
    logic [NUM_IRQ-1:0]   ack_q, ack_d;

    assign req_masked = irq_req & irq_mask;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .req_i   (req_masked),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

`ifdef INT_NESTING_EN
    logic [PC_W-1:0]  stk_epc_q [2];
    logic [IDX_W-1:0] stk_idx_q [2];
    logic [1:0]       sp_q, sp_d;
    logic             push, pop, top;

    // With sp in {1,2}, the top entry lives at index sp-1, i.e. the inverse of sp[0].
    assign top    = ~sp_q[0];
    assign nest_d = (sp_d != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                stk_epc_q[i] <= '0;
                stk_idx_q[i] <= '0;
            end
        end else begin
            sp_q <= sp_d;
            if (push) begin
                stk_epc_q[sp_q[0]] <= epc_q;
                stk_idx_q[sp_q[0]] <= idx_q;
            end
        end
    end
`else
    assign nest_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        epc_d   = epc_q;
`ifdef INT_NESTING_EN
        push    = 1'b0;
        pop     = 1'b0;
        sp_d    = sp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_valid && !branch_pending) begin
                    idx_d   = win_idx;
                    epc_d   = fetch_pc;
                    cnt_d   = CNT_W'(DEPTH - 1);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (eret) begin
                    state_d = ST_RETURN;
`ifdef INT_NESTING_EN
                // Pre-emption also waits out a taken branch so the saved PC is the real successor.
                end else if (win_valid && (win_idx < idx_q) && (sp_q != 2'd2) && !branch_pending) begin
                    push    = 1'b1;
                    sp_d    = sp_q + 2'd1;
                    idx_d   = win_idx;
                    epc_d   = fetch_pc;
                    cnt_d   = CNT_W'(DEPTH - 1);
                    state_d = ST_DRAIN;
`endif
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
`ifdef INT_NESTING_EN
                if (sp_q != 2'd0) begin
                    pop     = 1'b1;
                    sp_d    = sp_q - 2'd1;
                    epc_d   = stk_epc_q[top];
                    idx_d   = stk_idx_q[top];
                    state_d = ST_SERVICE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every output can be a plain register.
    always_comb begin
        flush_d    = '0;
        redir_pc_d = redir_pc_q;
        ack_d      = '0;
        if (state_d == ST_REDIRECT) begin
            flush_d    = DEPTH'(1);
            redir_pc_d = PC_W'(vec_addr(32'(VEC_BASE), 32'(idx_d), VEC_SHIFT));
            ack_d      = NUM_IRQ'(1) << idx_d;
        end else if (state_d == ST_RETURN) begin
            flush_d    = {1'b0, {(DEPTH-1){1'b1}}};
            redir_pc_d = epc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            epc_q         <= '0;
            stall_q       <= 1'b0;
            flush_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            ack_q         <= '0;
            active_q      <= 1'b0;
            avail_q       <= !branch_pending;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            epc_q         <= epc_d;
            stall_q       <= (state_d == ST_DRAIN);
            flush_q       <= flush_d;
            redir_valid_q <= (state_d == ST_REDIRECT) || (state_d == ST_RETURN);
            redir_pc_q    <= redir_pc_d;
            ack_q         <= ack_d;
            active_q      <= (state_d == ST_SERVICE) || ((state_d != ST_IDLE) && nest_d);
            avail_q       <= (state_d == ST_IDLE) && !branch_pending;
        end
    end

    assign stall_fetch       = stall_q;
    assign flush             = flush_q;
    assign pc_redirect_valid = redir_valid_q;
    assign pc_redirect       = redir_pc_q;
    assign epc               = epc_q;
    assign irq_ack           = ack_q;
    assign int_active        = active_q;
    assign available_for_int = avail_q;

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Self-checking bench for pipe_int_ctrl: directed scenarios plus randomized request/mask/PC service runs.
module tb_pipe_int_ctrl;

    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_req = '0;
    logic [3:0] irq_mask = '0;
    logic [9:0] fetch_pc = '0;
    logic       branch_pending = 1'b0;
    logic       eret = 1'b0;
    logic       stall_fetch;
    logic [2:0] flush;
    logic       pc_redirect_valid;
    logic [9:0] pc_redirect;
    logic [9:0] epc;
    logic [3:0] irq_ack;
    logic       int_active;
    logic       available_for_int;

    int checks = 0;
    int failures = 0;

    pipe_int_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .irq_req           (irq_req),
        .irq_mask          (irq_mask),
        .fetch_pc          (fetch_pc),
        .branch_pending    (branch_pending),
        .eret              (eret),
        .stall_fetch       (stall_fetch),
        .flush             (flush),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect       (pc_redirect),
        .epc               (epc),
        .irq_ack           (irq_ack),
        .int_active        (int_active),
        .available_for_int (available_for_int)
    );

    always #5 clk = ~clk;

    // Reference rules: lowest enabled index wins; vector = 0x300 + 4*index, wrapped to 10 bits.
    function automatic int lowestIdx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [9:0] vecOf(input int i);
        logic [31:0] t;
        t = 32'h300 + 32'(i) * 32'd4;
        return t[9:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_stall", 32'(stall_fetch), 0);
        checkOutput("rst_flush", 32'(flush), 0);
        checkOutput("rst_pcv", 32'(pc_redirect_valid), 0);
        checkOutput("rst_pc_redirect", 32'(pc_redirect), 0);
        checkOutput("rst_epc", 32'(epc), 0);
        checkOutput("rst_ack", 32'(irq_ack), 0);
        checkOutput("rst_int_active", 32'(int_active), 0);
        checkOutput("rst_available", 32'(available_for_int), 1);
    endtask

    // Request accepted on the next edge: DEPTH-1 stall cycles, then one redirect cycle, then SERVICE.
    task automatic enterService(input logic [3:0] req, input logic [9:0] pc, input int w, input logic nested);
        irq_req  = req;
        fetch_pc = pc;
        step();
        checkOutput("drain_stall", 32'(stall_fetch), 1);
        checkOutput("drain_epc", 32'(epc), 32'(pc));
        checkOutput("drain_int_active", 32'(int_active), 32'(nested));
        fetch_pc = 10'($urandom);
        for (int d = 1; d < DEPTH - 1; d++) begin
            step();
            checkOutput("drain_stall_hold", 32'(stall_fetch), 1);
            checkOutput("drain_pcv_low", 32'(pc_redirect_valid), 0);
        end
        step();
        checkOutput("redir_stall_low", 32'(stall_fetch), 0);
        checkOutput("redir_pcv", 32'(pc_redirect_valid), 1);
        checkOutput("redir_vector", 32'(pc_redirect), 32'(vecOf(w)));
        checkOutput("redir_ack", 32'(irq_ack), 32'(4'b0001 << w));
        checkOutput("redir_flush", 32'(flush), 32'b001);
        irq_req = '0;
        step();
        checkOutput("svc_int_active", 32'(int_active), 1);
        checkOutput("svc_pcv_low", 32'(pc_redirect_valid), 0);
        checkOutput("svc_ack_low", 32'(irq_ack), 0);
    endtask

    task automatic leaveService(input logic [9:0] pc, input logic stillActive);
        eret = 1'b1;
        step();
        eret = 1'b0;
        checkOutput("ret_pcv", 32'(pc_redirect_valid), 1);
        checkOutput("ret_target", 32'(pc_redirect), 32'(pc));
        checkOutput("ret_flush", 32'(flush), 32'b011);
        checkOutput("ret_int_active", 32'(int_active), 32'(stillActive));
        step();
        checkOutput("post_ret_pcv", 32'(pc_redirect_valid), 0);
        checkOutput("post_ret_int_active", 32'(int_active), 32'(stillActive));
        checkOutput("post_ret_available", 32'(available_for_int), 32'(!stillActive));
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] mask, input logic [9:0] pc);
        int w;
        irq_mask = mask;
        w = lowestIdx(req & mask);
        if (w < 0) begin
            irq_req = req;
            repeat (3) begin
                step();
                checkOutput("idle_no_stall", 32'(stall_fetch), 0);
                checkOutput("idle_no_pcv", 32'(pc_redirect_valid), 0);
                checkOutput("idle_available", 32'(available_for_int), 1);
            end
            irq_req = '0;
        end else begin
            enterService(req, pc, w, 1'b0);
            leaveService(pc, 1'b0);
        end
    endtask

    initial begin
        $display("[TB] start");
        step();
        checkReset();
        rst = 1'b1;
        step();
        checkOutput("idle_available_after_rst", 32'(available_for_int), 1);

        applyStimulus(4'b0100, 4'b1111, 10'h045);
        applyStimulus(4'b1010, 4'b1111, 10'h111);
        applyStimulus(4'b1111, 4'b0000, 10'h222);

        eret = 1'b1;
        step();
        eret = 1'b0;
        checkOutput("eret_idle_ignored_pcv", 32'(pc_redirect_valid), 0);
        checkOutput("eret_idle_ignored_active", 32'(int_active), 0);

        irq_mask       = 4'b1111;
        irq_req        = 4'b0001;
        branch_pending = 1'b1;
        repeat (2) begin
            step();
            checkOutput("branch_defer_stall", 32'(stall_fetch), 0);
            checkOutput("branch_defer_available", 32'(available_for_int), 0);
        end
        branch_pending = 1'b0;
        enterService(4'b0001, 10'h155, 0, 1'b0);
        leaveService(10'h155, 1'b0);

        irq_req  = 4'b0010;
        fetch_pc = 10'h0AA;
        step();
        checkOutput("pre_rst_drain", 32'(stall_fetch), 1);
        rst = 1'b0;
        step();
        checkReset();
        rst = 1'b1;
        enterService(4'b0010, 10'h0BB, 1, 1'b0);
        leaveService(10'h0BB, 1'b0);

        enterService(4'b0100, 10'h123, 2, 1'b0);
        irq_req = 4'b0001;
        eret    = 1'b1;
        step();
        eret = 1'b0;
        checkOutput("eret_wins_pcv", 32'(pc_redirect_valid), 1);
        checkOutput("eret_wins_target", 32'(pc_redirect), 32'h123);
        checkOutput("eret_wins_no_stall", 32'(stall_fetch), 0);
        step();
        checkOutput("after_ret_idle_stall", 32'(stall_fetch), 0);
        enterService(4'b0001, 10'h321, 0, 1'b0);
        leaveService(10'h321, 1'b0);

`ifdef INT_NESTING_EN
        irq_mask = 4'b1111;
        enterService(4'b1000, 10'h100, 3, 1'b0);
        enterService(4'b0100, 10'h1A0, 2, 1'b1);
        enterService(4'b0010, 10'h1B0, 1, 1'b1);
        irq_req = 4'b0001;
        repeat (3) begin
            step();
            checkOutput("nest_full_refused", 32'(stall_fetch), 0);
            checkOutput("nest_full_active", 32'(int_active), 1);
        end
        irq_req = '0;
        leaveService(10'h1B0, 1'b1);
        leaveService(10'h1A0, 1'b1);
        leaveService(10'h100, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 10'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
